jamming_sweep_scheduler: RTL and testbench

Sequences the 14-bit jamming DAC sawtooth as scheduled bursts rather than a free-running ramp.
- Holds a latched sweep configuration: low/high code, step, sweep count and inter-sweep gap.
- Runs N ramps separated by gaps at midscale, then returns to idle.
- Sits between the host/config logic and the DAC data pins, replacing the free-running generator's direct drive.

---
 rtl/jamming_pkg.sv | 44 ++++
 rtl/jamming_ramp_core.sv | 46 ++++
 rtl/jamming_sweep_scheduler.sv | 179 +++++++++++++++++
 tb/tb_jamming_sweep_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jamming_pkg.sv
// Shared types and constants for the jamming sweep scheduler.
// Holds the FSM state encoding, default config and config struct.
package jamming_pkg;

    localparam int DAC_W  = 14;
    localparam int STEP_W = 8;
    localparam int CNT_W  = 8;
    localparam int GAP_W  = 16;

    localparam logic [DAC_W-1:0]  MIDSCALE   = 14'd8192;
    localparam logic [DAC_W-1:0]  DEF_LO     = 14'd8192;
    localparam logic [DAC_W-1:0]  DEF_HI     = 14'd16383;
    localparam logic [STEP_W-1:0] DEF_STEP   = 8'd1;
    localparam logic [CNT_W-1:0]  DEF_SWEEPS = 8'd0;
    localparam logic [GAP_W-1:0]  DEF_GAP    = 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_GAP
    } state_e;

    typedef struct packed {
        logic [DAC_W-1:0]  lo;
        logic [DAC_W-1:0]  hi;
        logic [STEP_W-1:0] step;
        logic [CNT_W-1:0]  sweeps;
        logic [GAP_W-1:0]  gap;
    } sweep_cfg_t;

    localparam sweep_cfg_t DEF_CFG = '{
        lo:     DEF_LO,
        hi:     DEF_HI,
        step:   DEF_STEP,
        sweeps: DEF_SWEEPS,
        gap:    DEF_GAP
    };

    // A ramp needs a non-empty range and forward progress.
    function automatic logic cfg_ok(input sweep_cfg_t c);
        return (c.lo <= c.hi) && (c.step != '0);
    endfunction

endpackage

// File: rtl/jamming_ramp_core.sv
// Ramp code register with step/limit arithmetic.
// The sum is one bit wider than the code so it cannot wrap.
module jamming_ramp_core
    import jamming_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              park,
    input  logic              load,
    input  logic              advance,
    input  logic [DAC_W-1:0]  lo,
    input  logic [DAC_W-1:0]  hi,
    input  logic [STEP_W-1:0] step,
    output logic [DAC_W-1:0]  code,
    output logic              wrap
);

    logic [DAC_W-1:0] code_d, code_q;
    logic [DAC_W:0]   sum;

    // Next code: park beats load beats advance.
    always_comb begin
        sum    = {1'b0, code_q} + {{(DAC_W+1-STEP_W){1'b0}}, step};
        wrap   = sum > {1'b0, hi};
        code_d = code_q;
        if (park) begin
            code_d = MIDSCALE;
        end else if (load) begin
            code_d = lo;
        end else if (advance) begin
            code_d = sum[DAC_W-1:0];
        end
    end

    // Code register, parks at midscale on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= MIDSCALE;
        end else begin
            code_q <= code_d;
        end
    end

    assign code = code_q;

endmodule

// File: rtl/jamming_sweep_scheduler.sv
// Burst scheduler for the jamming DAC sawtooth: N ramps with
// midscale gaps, driven from a latched sweep configuration.
module jamming_sweep_scheduler
    import jamming_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DAC_W-1:0]  cfg_lo,
    input  logic [DAC_W-1:0]  cfg_hi,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [CNT_W-1:0]  cfg_sweeps,
    input  logic [GAP_W-1:0]  cfg_gap,
    output logic              cfg_err,
    input  logic              start,
    input  logic              abort,
    output logic [DAC_W-1:0]  dac_code,
    output logic              dac_valid,
    output logic              busy,
    output logic              sweep_tick,
    output logic              done,
    output logic              check_led
);

    state_e     state_d, state_q;
    sweep_cfg_t cfg_d, cfg_q, cfg_in;
    logic [CNT_W-1:0] sweep_cnt_d, sweep_cnt_q;
    logic [GAP_W-1:0] gap_cnt_d, gap_cnt_q;
    logic valid_d, valid_q;
    logic tick_d, tick_q;
    logic done_d, done_q;
    logic err_d, err_q;
    logic led_d, led_q;

    logic park, load, advance, wrap;
    logic [CNT_W:0] cnt_inc;
    logic last;

    jamming_ramp_core u_core (
        .clk     (clk),
        .rst     (rst),
        .park    (park),
        .load    (load),
        .advance (advance),
        .lo      (cfg_q.lo),
        .hi      (cfg_q.hi),
        .step    (cfg_q.step),
        .code    (dac_code),
        .wrap    (wrap)
    );

    // Next-state, counters and registered pulse outputs.
    always_comb begin
        cfg_in = '{
            lo:     cfg_lo,
            hi:     cfg_hi,
            step:   cfg_step,
            sweeps: cfg_sweeps,
            gap:    cfg_gap
        };
        cnt_inc     = {1'b0, sweep_cnt_q} + 1'b1;
        last        = (cfg_q.sweeps != '0) &&
                      (cnt_inc == {1'b0, cfg_q.sweeps});
        state_d     = state_q;
        cfg_d       = cfg_q;
        sweep_cnt_d = sweep_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        valid_d     = valid_q;
        tick_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        led_d       = led_q;
        park        = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            park        = 1'b1;
            valid_d     = 1'b0;
            sweep_cnt_d = '0;
            gap_cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_ok(cfg_in)) begin
                            cfg_d = cfg_in;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (start) begin
                        state_d     = ST_SWEEP;
                        load        = 1'b1;
                        valid_d     = 1'b1;
                        sweep_cnt_d = '0;
                        gap_cnt_d   = '0;
                    end
                end
                ST_SWEEP: begin
                    if (!wrap) begin
                        advance = 1'b1;
                    end else begin
                        tick_d = 1'b1;
                        led_d  = ~led_q;
                        if (cnt_inc[CNT_W]) begin
                            sweep_cnt_d = '1;
                        end else begin
                            sweep_cnt_d = cnt_inc[CNT_W-1:0];
                        end
                        if (last) begin
                            state_d     = ST_IDLE;
                            done_d      = 1'b1;
                            park        = 1'b1;
                            valid_d     = 1'b0;
                            sweep_cnt_d = '0;
                        end else if (cfg_q.gap == '0) begin
                            load = 1'b1;
                        end else begin
                            state_d   = ST_GAP;
                            park      = 1'b1;
                            valid_d   = 1'b0;
                            gap_cnt_d = cfg_q.gap - 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = ST_SWEEP;
                        load    = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    park    = 1'b1;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, config and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfg_q       <= DEF_CFG;
            sweep_cnt_q <= '0;
            gap_cnt_q   <= '0;
            valid_q     <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            sweep_cnt_q <= sweep_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            valid_q     <= valid_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            err_q       <= err_d;
            led_q       <= led_d;
        end
    end

    assign cfg_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign dac_valid  = valid_q;
    assign sweep_tick = tick_q;
    assign done       = done_q;
    assign cfg_err    = err_q;
    assign check_led  = led_q;

endmodule

// File: tb/tb_jamming_sweep_scheduler.sv
// Directed bench for jamming_sweep_scheduler with
// hand-computed expected codes and pulses.
module tb_jamming_sweep_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [13:0] cfg_lo = '0;
    logic [13:0] cfg_hi = '0;
    logic [7:0]  cfg_step = '0;
    logic [7:0]  cfg_sweeps = '0;
    logic [15:0] cfg_gap = '0;
    logic        cfg_err;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] dac_code;
    logic        dac_valid;
    logic        busy;
    logic        sweep_tick;
    logic        done;
    logic        check_led;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_led = 1'b0;

    jamming_sweep_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_lo     (cfg_lo),
        .cfg_hi     (cfg_hi),
        .cfg_step   (cfg_step),
        .cfg_sweeps (cfg_sweeps),
        .cfg_gap    (cfg_gap),
        .cfg_err    (cfg_err),
        .start      (start),
        .abort      (abort),
        .dac_code   (dac_code),
        .dac_valid  (dac_valid),
        .busy       (busy),
        .sweep_tick (sweep_tick),
        .done       (done),
        .check_led  (check_led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // code, valid, busy, tick, done in one call
    task automatic chk_out(input string tag, input int code,
                           input int v, input int b,
                           input int t, input int d);
        chk({tag, ".code"}, int'(dac_code), code);
        chk({tag, ".valid"}, int'(dac_valid), v);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".tick"}, int'(sweep_tick), t);
        chk({tag, ".done"}, int'(done), d);
        chk({tag, ".led"}, int'(check_led), int'(exp_led));
    endtask

    task automatic set_cfg(input int lo, input int hi, input int st,
                           input int sw, input int gp);
        cfg_lo     = 14'(lo);
        cfg_hi     = 14'(hi);
        cfg_step   = 8'(st);
        cfg_sweeps = 8'(sw);
        cfg_gap    = 16'(gp);
    endtask

    initial begin
        // reset
        #2 rst = 1'b1;
        #1;
        chk_out("rst", 8192, 0, 0, 0, 0);
        chk("rst.ready", int'(cfg_ready), 1);
        chk("rst.err", int'(cfg_err), 0);
        tick();
        rst = 1'b0;
        tick();

        // default config: full legacy ramp, continuous
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("def.first", 8192, 1, 1, 0, 0);
        chk("def.ready", int'(cfg_ready), 0);
        for (int i = 1; i < 8192; i++) begin
            tick();
            chk("def.code", int'(dac_code), 8192 + i);
            chk("def.tick", int'(sweep_tick), 0);
        end
        tick();
        exp_led = ~exp_led;
        chk_out("def.wrap", 8192, 1, 1, 1, 0);
        tick();
        chk_out("def.next", 8193, 1, 1, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_out("def.abort", 8192, 0, 0, 0, 0);

        // two-sweep burst with gap 3
        set_cfg(100, 110, 4, 2, 3);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("b.err", int'(cfg_err), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("b.s0", 100, 1, 1, 0, 0);
        tick();
        chk_out("b.s1", 104, 1, 1, 0, 0);
        tick();
        chk_out("b.s2", 108, 1, 1, 0, 0);
        tick();
        exp_led = ~exp_led;
        chk_out("b.g0", 8192, 0, 1, 1, 0);
        tick();
        chk_out("b.g1", 8192, 0, 1, 0, 0);
        tick();
        chk_out("b.g2", 8192, 0, 1, 0, 0);
        tick();
        chk_out("b.t0", 100, 1, 1, 0, 0);
        tick();
        chk_out("b.t1", 104, 1, 1, 0, 0);
        tick();
        chk_out("b.t2", 108, 1, 1, 0, 0);
        tick();
        exp_led = ~exp_led;
        chk_out("b.done", 8192, 0, 0, 1, 1);
        chk("b.ready", int'(cfg_ready), 1);
        tick();
        chk_out("b.idle", 8192, 0, 0, 0, 0);

        // rejected configs keep lo=100
        set_cfg(500, 400, 1, 0, 0);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("r1.err", int'(cfg_err), 1);
        tick();
        chk("r1.err_end", int'(cfg_err), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("r1.keep", 100, 1, 1, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_out("r1.abort", 8192, 0, 0, 0, 0);
        set_cfg(0, 10, 0, 0, 0);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("r2.err", int'(cfg_err), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r2.err_end", int'(cfg_err), 0);
        chk_out("r2.keep", 100, 1, 1, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // top-of-range step, start with cfg_valid ignored
        set_cfg(16200, 16383, 255, 0, 0);
        cfg_valid = 1'b1;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        chk_out("h.ign", 8192, 0, 0, 0, 0);
        chk("h.err", int'(cfg_err), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("h.s0", 16200, 1, 1, 0, 0);
        tick();
        exp_led = ~exp_led;
        chk_out("h.s1", 16200, 1, 1, 1, 0);
        tick();
        exp_led = ~exp_led;
        chk_out("h.s2", 16200, 1, 1, 1, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_out("h.abort", 8192, 0, 0, 0, 0);

        // abort beats start in IDLE
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk_out("as.0", 8192, 0, 0, 0, 0);
        tick();
        chk_out("as.1", 8192, 0, 0, 0, 0);

        // reset during GAP restores defaults
        set_cfg(100, 110, 4, 0, 5);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("rg.s0", 100, 1, 1, 0, 0);
        tick();
        tick();
        tick();
        exp_led = ~exp_led;
        chk_out("rg.gap", 8192, 0, 1, 1, 0);
        tick();
        #2 rst = 1'b1;
        #1;
        exp_led = 1'b0;
        chk_out("rg.rst", 8192, 0, 0, 0, 0);
        chk("rg.ready", int'(cfg_ready), 1);
        #1 rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("rg.def0", 8192, 1, 1, 0, 0);
        tick();
        chk_out("rg.def1", 8193, 1, 1, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_out("rg.end", 8192, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
